alu_exec_unit: RTL and testbench

- Consumer end of the issue-queue issue interface.
- Accepts one issued ALU op per cycle: cmd, op1, op2, phys_rd.
- Computes the result, pipelines it through LATENCY-1 extra stages, and buffers it in a result FIFO.
- Broadcasts the result as a phys_result valid/tag/data wakeup, which feeds issue-queue wakeup and the writeback arbiter.
- Credit-based backpressure to the issue side via issue_ready.

---
 rtl/alu_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle compute, LATENCY-1 pipeline stages, credit-guarded result FIFO
// broadcasting phys_result wakeups. Optional macro ALU_EXEC_X0_SUPPRESS_EN drops tag-0 results at FIFO push.

package common;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_t;
endpackage

module alu_exec_unit
  import common::*;
#(
  parameter int LATENCY           = 1,
  parameter int RESULT_FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alu_cmd_valid,
  output logic                 issue_ready,
  input  common::alu_cmd_t     issue_alu_cmd,
  input  logic [31:0]          issue_op1,
  input  logic [31:0]          issue_op2,
  input  logic [7:0]           phys_rd,
  output logic                 phys_result_valid,
  output logic [7:0]           phys_result_tag,
  output logic [31:0]          phys_result_data,
  input  logic                 wb_ready
);

  localparam int PTR_W  = $clog2(RESULT_FIFO_DEPTH);
  localparam int CNT_W  = $clog2(RESULT_FIFO_DEPTH + LATENCY) + 1;
  localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

  function automatic logic [31:0] alu_compute(alu_cmd_t cmd, logic [31:0] a, logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (cmd)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {31'd0, (a < b)};
      default:  return 32'd0;
    endcase
  endfunction

  logic              accept_s;
  logic [31:0]       result_s;
  logic              push_valid_s;
  logic              push_en_s;
  logic [7:0]        push_tag_s;
  logic [31:0]       push_data_s;
  logic [CNT_W-1:0]  inflight_s;
  logic              pop_s;

  logic [7:0]        fifo_tag_r  [RESULT_FIFO_DEPTH];
  logic [31:0]       fifo_data_r [RESULT_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  assign accept_s = alu_cmd_valid && issue_ready;
  assign result_s = alu_compute(issue_alu_cmd, issue_op1, issue_op2);

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [PIPE_N-1:0] pipe_valid_r;
      logic [7:0]        pipe_tag_r  [PIPE_N];
      logic [31:0]       pipe_data_r [PIPE_N];

      // Non-stalling result pipeline; stage 0 captures the result computed in the issue cycle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_valid_r <= '0;
          for (int i = 0; i < PIPE_N; i++) begin
            pipe_tag_r[i]  <= 8'd0;
            pipe_data_r[i] <= 32'd0;
          end
        end else if (flush) begin
          pipe_valid_r <= '0;
        end else begin
          pipe_valid_r[0] <= accept_s;
          pipe_tag_r[0]   <= phys_rd;
          pipe_data_r[0]  <= result_s;
          for (int i = 1; i < PIPE_N; i++) begin
            pipe_valid_r[i] <= pipe_valid_r[i-1];
            pipe_tag_r[i]   <= pipe_tag_r[i-1];
            pipe_data_r[i]  <= pipe_data_r[i-1];
          end
        end
      end

      // Count of valid pipeline stages, each holding a reserved FIFO credit
      always_comb begin
        inflight_s = '0;
        for (int i = 0; i < PIPE_N; i++) begin
          inflight_s = inflight_s + CNT_W'(pipe_valid_r[i]);
        end
      end

      assign push_valid_s = pipe_valid_r[PIPE_N-1];
      assign push_tag_s   = pipe_tag_r[PIPE_N-1];
      assign push_data_s  = pipe_data_r[PIPE_N-1];
    end else begin : g_nopipe
      assign inflight_s   = '0;
      assign push_valid_s = accept_s;
      assign push_tag_s   = phys_rd;
      assign push_data_s  = result_s;
    end
  endgenerate

`ifdef ALU_EXEC_X0_SUPPRESS_EN
  assign push_en_s = push_valid_s && (push_tag_s != 8'h00);
`else
  assign push_en_s = push_valid_s;
`endif

  assign pop_s = (count_r != '0) && wb_ready;

  // Result FIFO; flush wins over both push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < RESULT_FIFO_DEPTH; i++) begin
        fifo_tag_r[i]  <= 8'd0;
        fifo_data_r[i] <= 32'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en_s) begin
        fifo_tag_r[wr_ptr_r]  <= push_tag_s;
        fifo_data_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit check uses registered state only, so a same-cycle pop cannot raise it
  assign issue_ready       = (count_r + inflight_s) < CNT_W'(RESULT_FIFO_DEPTH);
  assign phys_result_valid = (count_r != '0);
  assign phys_result_tag   = fifo_tag_r[rd_ptr_r];
  assign phys_result_data  = fifo_data_r[rd_ptr_r];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one LATENCY=1/DEPTH=2 instance and one LATENCY=3/DEPTH=4 instance.
module tb_alu_exec_unit;
  import common::*;

  logic        clk;
  logic        rst;
  logic        flush1, v1, wb1, rdy1, rv1;
  alu_cmd_t    cmd1;
  logic [31:0] a1, b1, rdata1;
  logic [7:0]  rd1, rtag1;
  logic        flush3, v3, wb3, rdy3, rv3;
  alu_cmd_t    cmd3;
  logic [31:0] a3, b3, rdata3;
  logic [7:0]  rd3, rtag3;

  int checks;
  int failures;

  alu_exec_unit #(.LATENCY(1), .RESULT_FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .alu_cmd_valid(v1), .issue_ready(rdy1),
    .issue_alu_cmd(cmd1), .issue_op1(a1), .issue_op2(b1), .phys_rd(rd1),
    .phys_result_valid(rv1), .phys_result_tag(rtag1), .phys_result_data(rdata1), .wb_ready(wb1)
  );

  alu_exec_unit #(.LATENCY(3), .RESULT_FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .alu_cmd_valid(v3), .issue_ready(rdy3),
    .issue_alu_cmd(cmd3), .issue_op1(a3), .issue_op2(b3), .phys_rd(rd3),
    .phys_result_valid(rv3), .phys_result_tag(rtag3), .phys_result_data(rdata3), .wb_ready(wb3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue1(input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    v1 = 1'b1; cmd1 = c; a1 = a; b1 = b; rd1 = t;
  endtask

  task automatic issue3(input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    v3 = 1'b1; cmd3 = c; a3 = a; b3 = b; rd3 = t;
  endtask

  logic [3:0]  tv_cmd [13] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd8, 4'd9, 4'd8, 4'd15, 4'd0, 4'd7};
  logic [31:0] tv_a   [13] = '{32'hF0F0_1234, 32'hF0F0_0000, 32'hFFFF_0000, 32'h0000_0001, 32'h8000_0000,
                               32'h7000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                               32'h1234_5678, 32'hFFFF_FFFF, 32'hF000_0000};
  logic [31:0] tv_b   [13] = '{32'h0FF0_FFFF, 32'h0000_0F0F, 32'h0F0F_0F0F, 32'h0000_0024, 32'h0000_0004,
                               32'h0000_0004, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                               32'h9ABC_DEF0, 32'h0000_0002, 32'h0000_0023};
  logic [31:0] tv_exp [13] = '{32'h00F0_1234, 32'hF0F0_0F0F, 32'hF0F0_0F0F, 32'h0000_0010, 32'h0800_0000,
                               32'h0700_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001,
                               32'h0000_0000, 32'h0000_0001, 32'hFE00_0000};

  initial begin
    checks = 0;
    failures = 0;

    // Reset with random inputs
    rst = 1'b0;
    flush1 = 1'($urandom); v1 = 1'($urandom); wb1 = 1'($urandom);
    cmd1 = alu_cmd_t'(4'($urandom)); a1 = $urandom; b1 = $urandom; rd1 = 8'($urandom);
    flush3 = 1'($urandom); v3 = 1'($urandom); wb3 = 1'($urandom);
    cmd3 = alu_cmd_t'(4'($urandom)); a3 = $urandom; b3 = $urandom; rd3 = 8'($urandom);
    repeat (3) tick();
    rst = 1'b1;
    flush1 = 1'b0; v1 = 1'b0; wb1 = 1'b1;
    flush3 = 1'b0; v3 = 1'b0; wb3 = 1'b1;
    #1;
    chk("rst_valid1", 32'(rv1), 32'd0);
    chk("rst_tag1", 32'(rtag1), 32'd0);
    chk("rst_data1", rdata1, 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_valid3", 32'(rv3), 32'd0);
    chk("rst_ready3", 32'(rdy3), 32'd1);
    tick();

    // Single ADD, LATENCY=1
    issue1(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 8'h15);
    tick();
    v1 = 1'b0;
    chk("add_valid", 32'(rv1), 32'd1);
    chk("add_tag", 32'(rtag1), 32'h15);
    chk("add_data", rdata1, 32'h8000_0000);
    tick();
    chk("add_valid_gone", 32'(rv1), 32'd0);

    // Backpressure, DEPTH=2
    wb1 = 1'b0;
    chk("bp_ready_c0", 32'(rdy1), 32'd1);
    issue1(ALU_SUB, 32'd5, 32'd7, 8'h03);
    tick();
    chk("bp_ready_c1", 32'(rdy1), 32'd1);
    chk("bp_head_tag_c1", 32'(rtag1), 32'h03);
    chk("bp_head_data_c1", rdata1, 32'hFFFF_FFFE);
    issue1(ALU_SRA, 32'h8000_0000, 32'd4, 8'h04);
    tick();
    v1 = 1'b0;
    chk("bp_ready_c2", 32'(rdy1), 32'd0);
    chk("bp_head_tag_c2", 32'(rtag1), 32'h03);
    chk("bp_head_data_c2", rdata1, 32'hFFFF_FFFE);
    tick();
    chk("bp_ready_c3", 32'(rdy1), 32'd0);
    chk("bp_hold_tag_c3", 32'(rtag1), 32'h03);
    wb1 = 1'b1;
    #1;
    chk("bp_ready_same_cycle_pop", 32'(rdy1), 32'd0);
    tick();
    chk("bp_ready_after_pop", 32'(rdy1), 32'd1);
    chk("bp_second_valid", 32'(rv1), 32'd1);
    chk("bp_second_tag", 32'(rtag1), 32'h04);
    chk("bp_second_data", rdata1, 32'hF800_0000);
    tick();
    chk("bp_drained", 32'(rv1), 32'd0);

    // Compares back-to-back
    issue1(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 8'h20);
    tick();
    chk("slt_tag", 32'(rtag1), 32'h20);
    chk("slt_data", rdata1, 32'd1);
    issue1(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 8'h21);
    tick();
    v1 = 1'b0;
    chk("sltu_valid", 32'(rv1), 32'd1);
    chk("sltu_tag", 32'(rtag1), 32'h21);
    chk("sltu_data", rdata1, 32'd0);
    tick();
    chk("cmp_drained", 32'(rv1), 32'd0);

    // Op table, one per cycle with simultaneous push/pop
    for (int i = 0; i < 13; i++) begin
      issue1(alu_cmd_t'(tv_cmd[i]), tv_a[i], tv_b[i], 8'(8'h80 + i));
      tick();
      chk($sformatf("op%0d_valid", i), 32'(rv1), 32'd1);
      chk($sformatf("op%0d_tag", i), 32'(rtag1), 32'(8'h80 + i));
      chk($sformatf("op%0d_data", i), rdata1, tv_exp[i]);
    end
    v1 = 1'b0;
    tick();
    chk("table_drained", 32'(rv1), 32'd0);

    // Flush overrides push on LATENCY=1
    wb1 = 1'b0;
    issue1(ALU_ADD, 32'd3, 32'd4, 8'h60);
    tick();
    chk("fl1_pre_data", rdata1, 32'd7);
    flush1 = 1'b1;
    issue1(ALU_ADD, 32'd1, 32'd1, 8'h61);
    tick();
    flush1 = 1'b0; v1 = 1'b0;
    chk("fl1_valid", 32'(rv1), 32'd0);
    chk("fl1_ready", 32'(rdy1), 32'd1);
    tick();
    chk("fl1_discarded", 32'(rv1), 32'd0);
    wb1 = 1'b1;

    // Tag 0 handling
    issue1(ALU_ADD, 32'd1, 32'd1, 8'h00);
    tick();
    issue1(ALU_ADD, 32'd2, 32'd2, 8'h09);
`ifdef ALU_EXEC_X0_SUPPRESS_EN
    chk("x0_suppressed", 32'(rv1), 32'd0);
`else
    chk("x0_valid", 32'(rv1), 32'd1);
    chk("x0_tag", 32'(rtag1), 32'h00);
    chk("x0_data", rdata1, 32'd2);
`endif
    tick();
    v1 = 1'b0;
    chk("x9_valid", 32'(rv1), 32'd1);
    chk("x9_tag", 32'(rtag1), 32'h09);
    chk("x9_data", rdata1, 32'd4);
    tick();

    // LATENCY=3 basic latency
    issue3(ALU_ADD, 32'd10, 32'd20, 8'h31);
    tick();
    v3 = 1'b0;
    chk("l3_c1", 32'(rv3), 32'd0);
    tick();
    chk("l3_c2", 32'(rv3), 32'd0);
    tick();
    chk("l3_c3_valid", 32'(rv3), 32'd1);
    chk("l3_c3_tag", 32'(rtag3), 32'h31);
    chk("l3_c3_data", rdata3, 32'd30);
    tick();
    chk("l3_c4", 32'(rv3), 32'd0);

    // LATENCY=3 flush of three in-flight ops
    issue3(ALU_ADD, 32'd1, 32'd1, 8'h41);
    tick();
    issue3(ALU_ADD, 32'd2, 32'd2, 8'h42);
    tick();
    chk("l3f_ready_c2", 32'(rdy3), 32'd1);
    issue3(ALU_ADD, 32'd3, 32'd3, 8'h43);
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    chk("l3f_c3_valid", 32'(rv3), 32'd0);
    chk("l3f_c3_ready", 32'(rdy3), 32'd1);
    issue3(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 8'h44);
    tick();
    v3 = 1'b0;
    chk("l3f_c4_valid", 32'(rv3), 32'd0);
    tick();
    chk("l3f_c5_valid", 32'(rv3), 32'd0);
    tick();
    chk("l3f_c6_valid", 32'(rv3), 32'd1);
    chk("l3f_c6_tag", 32'(rtag3), 32'h44);
    chk("l3f_c6_data", rdata3, 32'h5555_5555);
    tick();
    chk("l3f_c7_valid", 32'(rv3), 32'd0);

    // LATENCY=3 credits include in-flight stages
    wb3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l3c_ready_c%0d", i), 32'(rdy3), 32'd1);
      issue3(ALU_SLL, 32'd1, 32'(i), 8'(8'h50 + i));
      tick();
    end
    v3 = 1'b0;
    chk("l3c_ready_c4", 32'(rdy3), 32'd0);
    tick();
    chk("l3c_ready_c5", 32'(rdy3), 32'd0);
    tick();
    chk("l3c_ready_c6", 32'(rdy3), 32'd0);
    chk("l3c_head_tag_c6", 32'(rtag3), 32'h50);
    wb3 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("l3c_pop%0d_tag", i), 32'(rtag3), 32'(8'h50 + i));
      chk($sformatf("l3c_pop%0d_data", i), rdata3, 32'(1) << i);
    end
    chk("l3c_ready_after", 32'(rdy3), 32'd1);
    tick();
    chk("l3c_drained", 32'(rv3), 32'd0);

    // Asynchronous reset mid-operation
    wb1 = 1'b0;
    issue1(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 8'h70);
    issue3(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 8'h71);
    tick();
    v1 = 1'b0; v3 = 1'b0;
    chk("mr_pre_valid", 32'(rv1), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_valid1", 32'(rv1), 32'd0);
    chk("mr_tag1", 32'(rtag1), 32'd0);
    chk("mr_data1", rdata1, 32'd0);
    chk("mr_ready1", 32'(rdy1), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr_post_valid1_c%0d", i), 32'(rv1), 32'd0);
      chk($sformatf("mr_post_valid3_c%0d", i), 32'(rv3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
